// File: rtl/vga_timing_generator.sv
// VGA raster timing (sync, display_enable, row/column, frame_start, frame_count); free-running, no backpressure.
// All outputs registered, 1 cycle after the counters; VGA_SYNC_ALIGN_EN delays hsync/vsync one extra cycle.
module vga_timing_generator #(
  parameter int unsigned H_VISIBLE         = 640,
  parameter int unsigned H_FRONT           = 16,
  parameter int unsigned H_SYNC            = 96,
  parameter int unsigned H_BACK            = 48,
  parameter int unsigned V_VISIBLE         = 480,
  parameter int unsigned V_FRONT           = 10,
  parameter int unsigned V_SYNC            = 2,
  parameter int unsigned V_BACK            = 33,
  parameter bit          SYNC_ACTIVE_LEVEL = 1'b0
) (
  input  logic        vga_clock,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic        display_enable,
  output logic [31:0] column,
  output logic [31:0] row,
  output logic        frame_start,
  output logic [31:0] frame_count
);

  localparam logic [31:0] H_TOTAL  = 32'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [31:0] V_TOTAL  = 32'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [31:0] H_VIS    = 32'(H_VISIBLE);
  localparam logic [31:0] V_VIS    = 32'(V_VISIBLE);
  localparam logic [31:0] HS_START = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] HS_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] VS_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [31:0] h_q, h_d;
  logic [31:0] v_q, v_d;
  logic [31:0] frames_q, frames_d;
  logic [31:0] column_q, column_d;
  logic [31:0] row_q, row_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    h_d      = h_q + 32'd1;
    v_d      = v_q;
    frames_d = frames_q;
    if (h_q == H_TOTAL - 32'd1) begin
      h_d = '0;
      if (v_q == V_TOTAL - 32'd1) begin
        v_d      = '0;
        frames_d = frames_q + 32'd1;
      end else begin
        v_d = v_q + 32'd1;
      end
    end

    // Output stage describes the counter value held this cycle.
    column_d      = h_q;
    row_d         = v_q;
    de_d          = (h_q < H_VIS) && (v_q < V_VIS);
    hsync_d       = ((h_q >= HS_START) && (h_q < HS_END)) ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
    vsync_d       = ((v_q >= VS_START) && (v_q < VS_END)) ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
    frame_start_d = (h_q == '0) && (v_q == '0);
    frame_count_d = frames_q;
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      frames_q      <= '0;
      column_q      <= '0;
      row_q         <= '0;
      frame_count_q <= '0;
      hsync_q       <= ~SYNC_ACTIVE_LEVEL;
      vsync_q       <= ~SYNC_ACTIVE_LEVEL;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frames_q      <= frames_d;
      column_q      <= column_d;
      row_q         <= row_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  // Extra stage matches the pixel stage's RGB register so sync lines up with colour.
  logic hsync_dly_q, hsync_dly_d;
  logic vsync_dly_q, vsync_dly_d;

  always_comb begin
    hsync_dly_d = hsync_q;
    vsync_dly_d = vsync_q;
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      hsync_dly_q <= ~SYNC_ACTIVE_LEVEL;
      vsync_dly_q <= ~SYNC_ACTIVE_LEVEL;
    end else begin
      hsync_dly_q <= hsync_dly_d;
      vsync_dly_q <= vsync_dly_d;
    end
  end

  assign hsync = hsync_dly_q;
  assign vsync = vsync_dly_q;
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`endif

  assign display_enable = de_q;
  assign column         = column_q;
  assign row            = row_q;
  assign frame_start    = frame_start_q;
  assign frame_count    = frame_count_q;

endmodule
